vga_timing_gen: RTL and testbench

//  Generates 640x480@60Hz VGA raster timing: pixel-rate divider, horizontal/vertical counters, sync pulses and display-enable.

---
 rtl/vga_timing_gen.sv | 76 +++++++
 tb/tb_vga_timing_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, zero-skew registered sync/bright decodes,
// pixel and frame strobes, and a free-running frame counter.
module vga_timing_gen #(
   parameter int DIV     = 4,
   parameter int H_TOTAL = 800,
   parameter int H_SYNC  = 96,
   parameter int H_START = 144,
   parameter int H_END   = 784,
   parameter int V_TOTAL = 525,
   parameter int V_SYNC  = 2,
   parameter int V_START = 35,
   parameter int V_END   = 515
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hSync,
   output logic       vSync,
   output logic       bright,
   output logic       pix_tick,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS  = 10'(H_SYNC);
   localparam logic [9:0] HST = 10'(H_START);
   localparam logic [9:0] HEN = 10'(H_END);
   localparam logic [9:0] VS  = 10'(V_SYNC);
   localparam logic [9:0] VST = 10'(V_START);
   localparam logic [9:0] VEN = 10'(V_END);

   logic [DW-1:0] div;
   logic          advance, h_wrap, v_wrap;
   logic [9:0]    h_nxt, v_nxt;

   assign advance = (div == DIV_LAST);
   assign h_wrap  = (hCount == H_LAST);
   assign v_wrap  = (vCount == V_LAST);

   always_comb begin
      h_nxt = h_wrap ? 10'd0 : hCount + 10'd1;
      v_nxt = vCount;
      if (h_wrap) v_nxt = v_wrap ? 10'd0 : vCount + 10'd1;
   end

   // Decodes are taken from the next-state counters so they land on the same edge as the counts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div         <= '0;
         hCount      <= '0;
         vCount      <= '0;
         hSync       <= 1'b0;
         vSync       <= 1'b0;
         bright      <= 1'b0;
         pix_tick    <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         div         <= advance ? '0 : div + DW'(1);
         pix_tick    <= advance;
         frame_start <= advance && h_wrap && v_wrap;
         if (advance) begin
            hCount <= h_nxt;
            vCount <= v_nxt;
            hSync  <= (h_nxt >= HS);
            vSync  <= (v_nxt >= VS);
            bright <= (h_nxt >= HST) && (h_nxt < HEN) && (v_nxt >= VST) && (v_nxt < VEN);
            if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (DIV=4,1,2) on a reduced 16x10 raster,
// checked every cycle against an arithmetic model plus directed literal points.
module tb_vga_timing_gen;
   localparam int HT = 16, HS = 3, HST = 5, HEN = 13;
   localparam int VT = 10, VS = 2, VST = 3, VEN = 8;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs, vs, br, pt, fs;
      logic [7:0] fc;
   } exp_t;

   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] h4, v4, h1, v1, h2, v2;
   logic hs4, vs4, br4, pt4, fs4, hs1, vs1, br1, pt1, fs1, hs2, vs2, br2, pt2, fs2;
   logic [7:0] fc4, fc1, fc2;

   vga_timing_gen #(.DIV(4), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_END(HEN),
      .V_TOTAL(VT), .V_SYNC(VS), .V_START(VST), .V_END(VEN)) u4 (
      .clk(clk), .rst(rst), .hCount(h4), .vCount(v4), .hSync(hs4), .vSync(vs4),
      .bright(br4), .pix_tick(pt4), .frame_start(fs4), .frame_cnt(fc4));
   vga_timing_gen #(.DIV(1), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_END(HEN),
      .V_TOTAL(VT), .V_SYNC(VS), .V_START(VST), .V_END(VEN)) u1 (
      .clk(clk), .rst(rst), .hCount(h1), .vCount(v1), .hSync(hs1), .vSync(vs1),
      .bright(br1), .pix_tick(pt1), .frame_start(fs1), .frame_cnt(fc1));
   vga_timing_gen #(.DIV(2), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_END(HEN),
      .V_TOTAL(VT), .V_SYNC(VS), .V_START(VST), .V_END(VEN)) u2 (
      .clk(clk), .rst(rst), .hCount(h2), .vCount(v2), .hSync(hs2), .vSync(vs2),
      .bright(br2), .pix_tick(pt2), .frame_start(fs2), .frame_cnt(fc2));

   exp_t got4, got1, got2;
   assign got4 = '{h4, v4, hs4, vs4, br4, pt4, fs4, fc4};
   assign got1 = '{h1, v1, hs1, vs1, br1, pt1, fs1, fc1};
   assign got2 = '{h2, v2, hs2, vs2, br2, pt2, fs2, fc2};

   int checks = 0, fails = 0;
   int n = 0;  // rising edges seen since reset was released

   always @(posedge clk or negedge rst)
      if (!rst) n <= 0;
      else n <= n + 1;

   // Pixel index = edges / DIV; everything else follows from raster arithmetic.
   function automatic exp_t model(input int edges, input int d);
      exp_t e;
      int p, h, v;
      p    = edges / d;
      h    = p % HT;
      v    = (p / HT) % VT;
      e.h  = 10'(h);
      e.v  = 10'(v);
      e.hs = (h >= HS);
      e.vs = (v >= VS);
      e.br = (h >= HST) && (h < HEN) && (v >= VST) && (v < VEN);
      e.pt = (edges > 0) && (edges % d == 0);
      e.fs = e.pt && (p % (HT * VT) == 0);
      e.fc = 8'((p / (HT * VT)) % 256);
      return e;
   endfunction

   task automatic chk(input string nm, input exp_t g, input exp_t e);
      checks++;
      if (g !== e) begin
         fails++;
         $display("FAIL %s n=%0d got=%h exp=%h", nm, n, g, e);
      end
   endtask

   always @(negedge clk) begin
      chk("model_div4", got4, model(n, 4));
      chk("model_div1", got1, model(n, 1));
      chk("model_div2", got2, model(n, 2));
   end

   task automatic lit(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s n=%0d got=%0d exp=%0d", nm, n, act, exp);
      end
   endtask

   task automatic wait_n(input int t);
      int k = 0;
      while (n != t && k < 60000) begin
         @(negedge clk);
         k++;
      end
      if (n != t) begin
         checks++;
         fails++;
         $display("FAIL wait_n timeout target=%0d got=%0d exp=%0d", t, n, t);
      end
   endtask

   task automatic restart_checks();
      wait_n(3);  lit("d4_h_before_4th", int'(h4), 0); lit("d4_pt_n3", int'(pt4), 0);
      wait_n(4);  lit("d4_h_at_4th", int'(h4), 1);      lit("d4_pt_n4", int'(pt4), 1);
      wait_n(5);  lit("d4_pt_n5", int'(pt4), 0);        lit("d4_h_n5", int'(h4), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      lit("rst_h4", int'(h4), 0); lit("rst_v1", int'(v1), 0); lit("rst_hs2", int'(hs2), 0);
      lit("rst_fs1", int'(fs1), 0); lit("rst_fc4", int'(fc4), 0); lit("rst_pt1", int'(pt1), 0);
      rst = 1'b1;
      lit("rel_no_fs", int'(fs1), 0);
      restart_checks();

      // Asynchronous reset mid-line, between edges.
      wait_n(30);
      @(posedge clk); #2 rst = 1'b0;
      #1;
      lit("async_h4", int'(h4), 0);  lit("async_h1", int'(h1), 0);  lit("async_v1", int'(v1), 0);
      lit("async_hs1", int'(hs1), 0); lit("async_pt4", int'(pt4), 0); lit("async_br1", int'(br1), 0);
      lit("async_fc2", int'(fc2), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      restart_checks();

      // Line wrap and hSync on the DIV=1 instance (n = v*HT + h in the first frame).
      wait_n(6);   lit("d1_hs_h6", int'(hs1), 1);
      wait_n(15);  lit("d1_h15", int'(h1), 15); lit("d1_v0", int'(v1), 0);
      wait_n(16);  lit("d1_wrap_h", int'(h1), 0); lit("d1_wrap_v", int'(v1), 1);
                   lit("d1_hs_h0", int'(hs1), 0); lit("d1_vs_v1", int'(vs1), 0);
      wait_n(18);  lit("d1_hs_h2", int'(hs1), 0);
      wait_n(19);  lit("d1_hs_h3", int'(hs1), 1);
      wait_n(32);  lit("d1_vs_v2", int'(vs1), 1);
      wait_n(37);  lit("br_5_2", int'(br1), 0);
      wait_n(52);  lit("br_4_3", int'(br1), 0);
      wait_n(53);  lit("br_5_3", int'(br1), 1);
      wait_n(124); lit("br_12_7", int'(br1), 1);
      wait_n(125); lit("br_13_7", int'(br1), 0);
      wait_n(133); lit("br_5_8", int'(br1), 0);

      // Frame wrap and frame period.
      wait_n(159); lit("f_h15", int'(h1), 15); lit("f_v9", int'(v1), 9); lit("f_fs_pre", int'(fs1), 0);
      wait_n(160); lit("f_h0", int'(h1), 0); lit("f_v0", int'(v1), 0);
                   lit("f_fs", int'(fs1), 1); lit("f_fc1", int'(fc1), 1); lit("f_vs0", int'(vs1), 0);
      wait_n(161); lit("f_fs_post", int'(fs1), 0);
      wait_n(319); lit("f2_fs_pre", int'(fs1), 0); lit("d2_fs_pre", int'(fs2), 0);
      wait_n(320); lit("f2_fs", int'(fs1), 1); lit("f2_fc", int'(fc1), 2);
                   lit("d2_fs", int'(fs2), 1); lit("d2_fc", int'(fc2), 1);
      wait_n(639); lit("d4_h15", int'(h4), 15); lit("d4_v9", int'(v4), 9); lit("d4_fs_pre", int'(fs4), 0);
      wait_n(640); lit("d4_fs", int'(fs4), 1); lit("d4_fc", int'(fc4), 1); lit("d4_h0", int'(h4), 0);

      // Frame counter wrap after 256 frames on the DIV=1 instance.
      wait_n(40959); lit("fc_255", int'(fc1), 255); lit("fc_pre_fs", int'(fs1), 0);
      wait_n(40960); lit("fc_wrap", int'(fc1), 0); lit("fc_wrap_fs", int'(fs1), 1);
                     lit("d2_fc128", int'(fc2), 128);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
